// File: rtl/multi_edge_detector_if.sv
// Bundle of the multi_edge_detector pin-side inputs and status outputs.
// edge_pulse is a valid-only strobe (no ready): it is high for exactly one cycle per
// qualified edge and must be taken that cycle; pending/clr form the held, acknowledged path.
interface multi_edge_detector_if #(
   parameter int NUM_CH = 4
);
   logic [NUM_CH-1:0]   sig_in;
   logic [2*NUM_CH-1:0] mode;
   logic [NUM_CH-1:0]   clr;
   logic [NUM_CH-1:0]   level;
   logic [NUM_CH-1:0]   edge_pulse;
   logic [NUM_CH-1:0]   pending;
   logic [NUM_CH-1:0]   overflow;
   logic                any_pending;

   modport master (
      output sig_in, mode, clr,
      input  level, edge_pulse, pending, overflow, any_pending
   );

   modport slave (
      input  sig_in, mode, clr,
      output level, edge_pulse, pending, overflow, any_pending
   );
endinterface

// File: rtl/multi_edge_detector.sv
// Multi-channel synchronising edge detector with per-channel polarity select and sticky
// pending/overflow flags (write-1-to-clear). Optional glitch filter: define EDGE_FILT_EN.
module multi_edge_detector #(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int RST_LEVEL   = 1,
   parameter int FILT_LEN    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   multi_edge_detector_if.slave  bus
);

   localparam int   SS      = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam logic RST_BIT = (RST_LEVEL != 0);

   logic [NUM_CH-1:0] s;
   logic [NUM_CH-1:0] level_w;
   logic [NUM_CH-1:0] hist_q;
   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] fall;
   logic [NUM_CH-1:0] q;
   logic [NUM_CH-1:0] pulse_q;
   logic [NUM_CH-1:0] pend_q;
   logic [NUM_CH-1:0] ovf_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [SS-1:0] chain_q;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            chain_q <= {SS{RST_BIT}};
         end else begin
            chain_q <= {chain_q[SS-2:0], bus.sig_in[g]};
         end
      end

      assign s[g] = chain_q[SS-1];

`ifdef EDGE_FILT_EN
      localparam int            CW      = $clog2(FILT_LEN + 1);
      localparam logic [CW-1:0] CNT_TOP = CW'(FILT_LEN - 1);

      logic [CW-1:0] cnt_q;
      logic          lvl_q;
      logic          s_next;

      // The counter watches the value s takes on the next edge, so a change that stays
      // stable for FILT_LEN samples reaches level only FILT_LEN-1 cycles after s would.
      assign s_next = chain_q[SS-2];

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            lvl_q <= RST_BIT;
            cnt_q <= '0;
         end else if (s_next != lvl_q) begin
            if (cnt_q == CNT_TOP) begin
               lvl_q <= s_next;
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end

      assign level_w[g] = lvl_q;
`else
      assign level_w[g] = s[g];
`endif
   end

   assign rise = level_w & ~hist_q;
   assign fall = ~level_w & hist_q;

   always_comb begin
      q = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         case (bus.mode[2*i +: 2])
            2'b01:   q[i] = rise[i];
            2'b10:   q[i] = fall[i];
            2'b11:   q[i] = rise[i] | fall[i];
            default: q[i] = 1'b0;
         endcase
      end
   end

   // A new edge in the same cycle as clr wins: pending stays set and overflow restarts at 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist_q  <= {NUM_CH{RST_BIT}};
         pulse_q <= '0;
         pend_q  <= '0;
         ovf_q   <= '0;
      end else begin
         hist_q  <= level_w;
         pulse_q <= q;
         for (int i = 0; i < NUM_CH; i++) begin
            if (q[i]) begin
               pend_q[i] <= 1'b1;
               if (bus.clr[i]) begin
                  ovf_q[i] <= 1'b0;
               end else if (pend_q[i]) begin
                  ovf_q[i] <= 1'b1;
               end
            end else if (bus.clr[i]) begin
               pend_q[i] <= 1'b0;
               ovf_q[i]  <= 1'b0;
            end
         end
      end
   end

   assign bus.level       = level_w;
   assign bus.edge_pulse  = pulse_q;
   assign bus.pending     = pend_q;
   assign bus.overflow    = ovf_q;
   assign bus.any_pending = |pend_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: expected pulses (cycle, vector) go into a queue at
// stimulus time and a negedge monitor pops and compares them; flags are checked in line.
module tb_multi_edge_detector;

   localparam int NUM_CH      = 4;
   localparam int SYNC_STAGES = 2;
   localparam int FILT_LEN    = 4;
`ifdef EDGE_FILT_EN
   localparam int LAT = SYNC_STAGES + FILT_LEN;
`else
   localparam int LAT = SYNC_STAGES + 1;
`endif
   localparam int EW = 32 + NUM_CH;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic mon_en = 1'b0;
   int   c;

   logic [EW-1:0] exp_q[$];

   multi_edge_detector_if #(.NUM_CH(NUM_CH)) bus ();

   multi_edge_detector #(
      .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .RST_LEVEL(1), .FILT_LEN(FILT_LEN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout at cycle %0d, required finish", cyc);
      $fatal(1, "watchdog expired");
   end

   // driver and check tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int t, input logic [NUM_CH-1:0] v);
      exp_q.push_back({32'(t), v});
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (mon_en && bus.edge_pulse !== '0) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pulse_unexpected: got %b at cycle %0d, required none", bus.edge_pulse, cyc);
         end else begin
            chk("pulse", {32'(cyc), bus.edge_pulse}, exp_q.pop_front());
         end
      end
   end

   initial begin
      bus.sig_in = '1;
      bus.mode   = '0;
      bus.clr    = '0;
      rst_n      = 1'b0;
      tick(3);
      chk("rst_pulse",    bus.edge_pulse,  0);
      chk("rst_pending",  bus.pending,     0);
      chk("rst_overflow", bus.overflow,    0);
      chk("rst_level",    bus.level,       4'hF);
      chk("rst_any",      bus.any_pending, 0);

      mon_en   = 1'b1;
      bus.mode = 8'b00_10_11_01;
      rst_n    = 1'b1;
      tick(20);
      chk("idle_pending", bus.pending,     0);
      chk("idle_level",   bus.level,       4'hF);
      chk("idle_any",     bus.any_pending, 0);

      // ch0 rise: latency and pending timing
      bus.sig_in[0] = 1'b0;
      tick(LAT + 5);
      chk("ch0_fall_ignored", bus.pending[0], 0);
      c = cyc; bus.sig_in[0] = 1'b1; push(c + LAT, 4'b0001);
      tick(LAT - 1);
      chk("ch0_pend_early", bus.pending[0], 0);
      tick(1);
      chk("ch0_pend", bus.pending[0], 1);
      chk("ch0_any",  bus.any_pending, 1);
      bus.clr = 4'b0001; tick(1); bus.clr = '0;
      chk("ch0_clr", bus.pending, 0);
      chk("ch0_any_clr", bus.any_pending, 0);

      // ch1 both edges, overflow, then set-wins
      c = cyc; bus.sig_in[1] = 1'b0; push(c + LAT, 4'b0010);
      tick(LAT + 1);
      chk("ch1_pend1", bus.pending[1], 1);
      chk("ch1_ovf1",  bus.overflow[1], 0);
      tick(10 - LAT - 1);
      c = cyc; bus.sig_in[1] = 1'b1; push(c + LAT, 4'b0010);
      tick(LAT + 1);
      chk("ch1_pend2", bus.pending[1], 1);
      chk("ch1_ovf2",  bus.overflow[1], 1);
      c = cyc; bus.sig_in[1] = 1'b0; push(c + LAT, 4'b0010);
      tick(LAT - 1); bus.clr = 4'b0010; tick(1); bus.clr = '0;
      chk("ch1_setwin_pend", bus.pending[1], 1);
      chk("ch1_setwin_ovf",  bus.overflow[1], 0);
      bus.clr = 4'b0010; tick(1); bus.clr = '0;
      chk("ch1_clr", bus.pending[1], 0);
      bus.sig_in[1] = 1'b1; push(cyc + LAT, 4'b0010);
      tick(LAT + 2);
      bus.clr = 4'b0010; tick(1); bus.clr = '0;

      // ch2 fall only, clr coinciding with a qualified edge
      c = cyc; bus.sig_in[2] = 1'b0; push(c + LAT, 4'b0100);
      tick(LAT + 1);
      chk("ch2_pend1", bus.pending[2], 1);
      bus.sig_in[2] = 1'b1;
      tick(LAT + 4);
      c = cyc; bus.sig_in[2] = 1'b0; push(c + LAT, 4'b0100);
      tick(LAT - 1); bus.clr = 4'b0100; tick(1);
      chk("ch2_setwin_pend", bus.pending[2], 1);
      chk("ch2_setwin_ovf",  bus.overflow[2], 0);
      tick(1); bus.clr = '0;
      chk("ch2_clr_pend", bus.pending[2], 0);
      chk("ch2_clr_ovf",  bus.overflow[2], 0);
      bus.sig_in[2] = 1'b1;
      tick(LAT + 2);

      // ch3 off, then enabled while stably high
      for (int k = 0; k < 4; k++) begin
         bus.sig_in[3] = ~bus.sig_in[3];
         tick(LAT + 2);
      end
      chk("ch3_off_pend", bus.pending[3], 0);
      bus.mode[7:6] = 2'b01;
      tick(10);
      chk("ch3_enable_pend", bus.pending[3], 0);
      bus.sig_in[3] = 1'b0;
      tick(LAT + 3);
      chk("ch3_fall_pend", bus.pending[3], 0);
      c = cyc; bus.sig_in[3] = 1'b1; push(c + LAT, 4'b1000);
      tick(LAT + 1);
      chk("ch3_rise_pend", bus.pending[3], 1);
      bus.mode = '0;
      tick(2);
      chk("mode_off_keeps_pend", bus.pending, 4'b1000);
      bus.clr = 4'hF; tick(1); bus.clr = '0;
      chk("clr_all", bus.pending, 0);

      // two channels on the same cycle
      bus.mode = 8'b00_10_11_01;
      c = cyc; bus.sig_in[0] = 1'b0; bus.sig_in[1] = 1'b0; push(c + LAT, 4'b0010);
      tick(LAT + 3);
      c = cyc; bus.sig_in[0] = 1'b1; bus.sig_in[1] = 1'b1; push(c + LAT, 4'b0011);
      tick(LAT + 1);
      chk("dual_pend", bus.pending,  4'b0011);
      chk("dual_ovf",  bus.overflow, 4'b0010);
      bus.clr = 4'hF; tick(1); bus.clr = '0;

`ifdef EDGE_FILT_EN
      bus.sig_in[0] = 1'b0;
      tick(LAT + 3);
      bus.sig_in[0] = 1'b1; tick(3); bus.sig_in[0] = 1'b0;
      tick(LAT + 5);
      chk("filt_glitch_pend", bus.pending[0], 0);
      c = cyc; bus.sig_in[0] = 1'b1; push(c + LAT, 4'b0001);
      tick(6); bus.sig_in[0] = 1'b0;
      tick(LAT + 3);
      chk("filt_pulse_pend", bus.pending[0], 1);
      bus.clr = 4'hF; tick(1); bus.clr = '0;
`endif

      // reset landing on a pulse in flight
      bus.sig_in[0] = 1'b0;
      tick(LAT + 3);
      c = cyc; bus.sig_in[0] = 1'b1;
      tick(LAT - 1);
      rst_n = 1'b0;
      tick(1);
      chk("midrst_pulse", bus.edge_pulse, 0);
      chk("midrst_pend",  bus.pending,    0);
      chk("midrst_ovf",   bus.overflow,   0);
      chk("midrst_level", bus.level,      4'hF);
      rst_n = 1'b1;
      tick(LAT + 8);
      chk("post_rst_pend", bus.pending, 0);

      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
